// File: rtl/prime_check_seq.sv
// Sequential primality checker: trial division with a bit-serial restoring
// remainder unit, early exit on the first divisor, valid/ready on both sides.
module prime_check_seq #(
  parameter int WIDTH     = 16,
  parameter bit SKIP_EVEN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_prime,
  output logic [WIDTH-1:0] out_factor,
  output logic             busy
);

  localparam int KW = $clog2(WIDTH);

  typedef enum logic [2:0] {IDLE, SCREEN, TEST, DIV, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] n_q, n_next;
  logic [WIDTH-1:0] d_q, d_next;
  logic [WIDTH-1:0] factor_q, factor_next;
  logic [WIDTH:0]   rem_q, rem_next;
  logic [WIDTH:0]   rem_shift, rem_div;
  logic [KW-1:0]    k_q, k_next;
  logic             prime_q, prime_next;
  logic [2*WIDTH-1:0] d_sq;

  assign in_ready   = (state == IDLE);
  assign busy       = (state != IDLE);
  assign out_valid  = (state == DONE);
  assign out_prime  = prime_q;
  assign out_factor = factor_q;

  // rem < d always holds between steps, so its top bit is zero before the shift
  always_comb begin
    d_sq      = {{WIDTH{1'b0}}, d_q} * {{WIDTH{1'b0}}, d_q};
    rem_shift = {rem_q[WIDTH-1:0], n_q[k_q]};
    rem_div   = (rem_shift >= {1'b0, d_q}) ? rem_shift - {1'b0, d_q} : rem_shift;
  end

  always_comb begin
    state_next  = state;
    n_next      = n_q;
    d_next      = d_q;
    rem_next    = rem_q;
    k_next      = k_q;
    prime_next  = prime_q;
    factor_next = factor_q;
    case (state)
      IDLE: begin
        if (in_valid) begin
          n_next      = in_data;
          d_next      = WIDTH'(2);
          prime_next  = 1'b0;
          factor_next = '0;
          state_next  = SCREEN;
        end
      end
      SCREEN: begin
        if (n_q < WIDTH'(2)) begin
          prime_next = 1'b0;
          state_next = DONE;
        end else if (n_q < WIDTH'(4)) begin
          prime_next = 1'b1;
          state_next = DONE;
        end else begin
          state_next = TEST;
        end
      end
      TEST: begin
        if (d_sq > {{WIDTH{1'b0}}, n_q}) begin
          prime_next  = 1'b1;
          factor_next = '0;
          state_next  = DONE;
        end else begin
          rem_next   = '0;
          k_next     = KW'(WIDTH - 1);
          state_next = DIV;
        end
      end
      DIV: begin
        rem_next = rem_div;
        k_next   = k_q - 1'b1;
        if (k_q == '0) begin
          if (rem_div == '0) begin
            prime_next  = 1'b0;
            factor_next = d_q;
            state_next  = DONE;
          end else begin
            if (SKIP_EVEN)
              d_next = (d_q == WIDTH'(2)) ? WIDTH'(3) : d_q + WIDTH'(2);
            else
              d_next = d_q + WIDTH'(1);
            state_next = TEST;
          end
        end
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_q      <= '0;
      d_q      <= '0;
      rem_q    <= '0;
      k_q      <= '0;
      prime_q  <= 1'b0;
      factor_q <= '0;
    end else begin
      n_q      <= n_next;
      d_q      <= d_next;
      rem_q    <= rem_next;
      k_q      <= k_next;
      prime_q  <= prime_next;
      factor_q <= factor_next;
    end
  end

endmodule
